// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce / pulse-generator block.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO   = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } state_e;

  localparam int unsigned GLITCH_CNT_W = 8;
  localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = 8'hFF;

endpackage

// File: rtl/debounce_pulse_gen_sync_chain.sv
// Multi-flop synchroniser for an asynchronous single-bit input; q is the last stage.
module sync_chain #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_pulse_gen.sv
// Synchronise, debounce and edge-detect a bouncy input; one-cycle pulse per debounced rise.
// Optional rejected-glitch counter enabled by defining DEBOUNCE_GLITCH_CNT_EN.
module debounce_pulse_gen
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  input  logic enable,
  output logic pulse_out,
  output logic level_out
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_d;
  logic             pulse_d;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (raw_in),
    .q  (sync_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE_LO;
      cnt_q     <= '0;
      level_out <= 1'b0;
      pulse_out <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_out <= level_d;
      pulse_out <= pulse_d;
    end
  end

  // Disabling drops any in-progress check back to the stable state it came from.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_out;
    pulse_d = 1'b0;
    unique case (state_q)
      IDLE_LO: begin
        if (enable && sync_q) begin
          state_d = CHK_HI;
          cnt_d   = CNT_W'(1);
        end
      end
      CHK_HI: begin
        if (!enable || !sync_q) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (enable && !sync_q) begin
          state_d = CHK_LO;
          cnt_d   = CNT_W'(1);
        end
      end
      CHK_LO: begin
        if (!enable || sync_q) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic glitch_c;

  assign glitch_c = enable && (((state_q == CHK_HI) && !sync_q) ||
                               ((state_q == CHK_LO) &&  sync_q));

  // Saturating count of aborted qualifications.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_cnt <= '0;
    end else if (glitch_c && (glitch_cnt != GLITCH_CNT_MAX)) begin
      glitch_cnt <= glitch_cnt + GLITCH_CNT_W'(1);
    end
  end
`endif

endmodule
